bus_sequencer: RTL and testbench
================================

BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 The block SHALL have parameter T_SETUP, default 1, the cycle count during which chip select is asserted before the strobe (legal 1..15).
REQ-002 The block SHALL have parameter T_STROBE, default 3, the cycle count during which brd_n/bwr_n is low (legal 1..15).
REQ-003 The block SHALL have parameter T_HOLD, default 1, the cycle count during which chip select stays asserted after the strobe (legal 1..15).
REQ-004 Ports SHALL be as follows:
 fclk  in  1  sole clock; all state changes on its rising edge
 rst  in  1  synchronous reset, active-high
 w_req  in  1  w5300 requester, level request
 w_rnw  in  1  1=read, 0=write
 w_addr  in  10  w5300 register address
 w_wdata  in  8  w5300 write data
 w_ack  out  1  one-cycle completion pulse
 s_req  in  1  sl811 requester, level request
 s_rnw  in  1  1=read, 0=write
 s_a0  in  1  sl811 address/data select
 s_wdata  in  8  sl811 write data
 s_ack  out  1  one-cycle completion pulse
 rdata  out  8  read data of last completed read
 busy  out  1  high when state is not IDLE
 w5300_addr  out  10  shared-bus address to w5300
 w5300_cs_n  out  1  w5300 select
 sl811_a0  out  1  sl811 A0
 sl811_cs_n  out  1  sl811 select
 brd_n  out  1  shared read strobe
 bwr_n  out  1  shared write strobe
 bd_out  out  8  shared data bus drive value
 bd_oe  out  1  shared data bus output enable
 bd_in  in  8  shared data bus sampled value

Function
REQ-005 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-006 The FSM SHALL have states IDLE, SETUP, STROBE, HOLD; SETUP lasts T_SETUP, STROBE lasts T_STROBE, HOLD lasts T_HOLD cycles, counted by a 4-bit down-counter.
REQ-007 In IDLE with neither ack output high, a pending request SHALL be granted: addr/rnw/wdata and requester ID captured, state -> SETUP next cycle.
REQ-008 Arbitration SHALL be round-robin: single request is granted directly; simultaneous requests grant the requester not granted last; after reset the last-grant marker SHALL be sl811 (w5300 wins first tie).
REQ-009 Transitions: SETUP -> STROBE, STROBE -> HOLD, HOLD -> IDLE, each when the counter reaches its terminal count; no other transitions except reset.
REQ-010 The granted chip's cs_n SHALL be low in every SETUP, STROBE and HOLD cycle and high in IDLE; the other cs_n SHALL stay high.
REQ-011 brd_n (read) or bwr_n (write) SHALL be low exactly during STROBE cycles; never both low.
REQ-012 w5300_addr / sl811_a0 SHALL hold the captured value from SETUP through HOLD and keep it in IDLE until the next grant.
REQ-013 For writes bd_oe SHALL be 1 and bd_out = captured wdata from SETUP through HOLD; bd_oe SHALL be 0 for reads and in IDLE.
REQ-014 For reads rdata SHALL load bd_in on the last STROBE cycle and hold until the next read completes; writes SHALL not alter rdata.
REQ-015 The granted requester's ack SHALL pulse high for exactly the first IDLE cycle after HOLD; rdata is valid in that cycle.
REQ-016 Requesters SHALL drop req in the cycle after ack; no grant occurs in an ack cycle, so back-to-back transfers have one dead IDLE cycle (total per transfer T_SETUP+T_STROBE+T_HOLD+1 cycles, grant-to-ack).
REQ-017 Request inputs changing after grant SHALL not affect the transfer in progress.

Reset
REQ-018 While rst is high on a clock edge: state IDLE, counter 0, w5300_cs_n=1, sl811_cs_n=1, brd_n=1, bwr_n=1, bd_oe=0, bd_out=0, w5300_addr=0, sl811_a0=0, rdata=0, w_ack=0, s_ack=0, busy=0, last-grant=sl811.
REQ-019 Reset during any non-IDLE state SHALL abort the transfer on that edge with no ack issued.

Verification
REQ-020 Defaults; w_req write addr 0x155 data 0xA5 -> cs_n low cycles 1-5, bwr_n low cycles 2-4, bd_oe 1 cycles 1-5, w_ack cycle 6.
REQ-021 s_req read s_a0=1, bd_in=0x3C during strobe -> sl811_cs_n low, brd_n low 3 cycles, rdata=0x3C at s_ack, bwr_n stays 1.
REQ-022 w_req and s_req raised same cycle after reset -> w5300 served first, sl811 next, exactly one dead IDLE cycle between.
REQ-023 Both requesters held continuously for 4 transfers -> grants alternate w,s,w,s.
REQ-024 rst asserted in STROBE of a read -> next cycle all strobes/cs_n high, bd_oe 0, no ack, rdata 0.
REQ-025 T_SETUP=2,T_STROBE=5,T_HOLD=3 -> cs_n low 10 cycles, strobe low 5 cycles, ack 11 cycles after grant.

Source files
------------

// File: rtl/bus_sequencer_if.sv
// Requester handshakes and shared-bus pins of the w5300/sl811 bus sequencer.
// The sequencer takes the master view; the requesters and the bus take the slave view.
interface bus_sequencer_if;
  logic       w_req;
  logic       w_rnw;
  logic [9:0] w_addr;
  logic [7:0] w_wdata;
  logic       w_ack;
  logic       s_req;
  logic       s_rnw;
  logic       s_a0;
  logic [7:0] s_wdata;
  logic       s_ack;
  logic [7:0] rdata;
  logic       busy;
  logic [9:0] w5300_addr;
  logic       w5300_cs_n;
  logic       sl811_a0;
  logic       sl811_cs_n;
  logic       brd_n;
  logic       bwr_n;
  logic [7:0] bd_out;
  logic       bd_oe;
  logic [7:0] bd_in;

  modport master (
    input  w_req, w_rnw, w_addr, w_wdata, s_req, s_rnw, s_a0, s_wdata, bd_in,
    output w_ack, s_ack, rdata, busy, w5300_addr, w5300_cs_n, sl811_a0, sl811_cs_n,
           brd_n, bwr_n, bd_out, bd_oe
  );

  modport slave (
    output w_req, w_rnw, w_addr, w_wdata, s_req, s_rnw, s_a0, s_wdata, bd_in,
    input  w_ack, s_ack, rdata, busy, w5300_addr, w5300_cs_n, sl811_a0, sl811_cs_n,
           brd_n, bwr_n, bd_out, bd_oe
  );
endinterface

// File: rtl/bus_sequencer.sv
// Round-robin sequencer sharing one async 8-bit bus between a w5300 and an sl811.
// Every output is a flop computed from the next state, so pins change cleanly on fclk.
module bus_sequencer #(
  parameter int unsigned T_SETUP  = 1,
  parameter int unsigned T_STROBE = 3,
  parameter int unsigned T_HOLD   = 1
) (
  input  logic            fclk,
  input  logic            rst,
  bus_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  localparam logic [3:0] SETUP_LAST  = 4'(T_SETUP - 1);
  localparam logic [3:0] STROBE_LAST = 4'(T_STROBE - 1);
  localparam logic [3:0] HOLD_LAST   = 4'(T_HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       gnt_sl_q, gnt_sl_d;   // owner of the current/last grant, 1 = sl811
  logic       rnw_q, rnw_d;
  logic [9:0] w5300_addr_q, w5300_addr_d;
  logic       sl811_a0_q, sl811_a0_d;
  logic [7:0] bd_out_q, bd_out_d;
  logic [7:0] rdata_q, rdata_d;
  logic       w_ack_q, w_ack_d;
  logic       s_ack_q, s_ack_d;
  logic       busy_q, busy_d;
  logic       w5300_cs_n_q, w5300_cs_n_d;
  logic       sl811_cs_n_q, sl811_cs_n_d;
  logic       brd_n_q, brd_n_d;
  logic       bwr_n_q, bwr_n_d;
  logic       bd_oe_q, bd_oe_d;
  logic       pick_sl;
  logic       active;
  logic       strobe;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt_sl_d     = gnt_sl_q;
    rnw_d        = rnw_q;
    w5300_addr_d = w5300_addr_q;
    sl811_a0_d   = sl811_a0_q;
    bd_out_d     = bd_out_q;
    rdata_d      = rdata_q;
    w_ack_d      = 1'b0;
    s_ack_d      = 1'b0;
    pick_sl      = 1'b0;

    case (state_q)
      IDLE: begin
        // An ack cycle never grants, which gives the dead cycle between transfers.
        if (!w_ack_q && !s_ack_q && (bus.w_req || bus.s_req)) begin
          pick_sl  = bus.s_req && (!bus.w_req || !gnt_sl_q);
          gnt_sl_d = pick_sl;
          state_d  = SETUP;
          cnt_d    = SETUP_LAST;
          if (pick_sl) begin
            rnw_d      = bus.s_rnw;
            sl811_a0_d = bus.s_a0;
            bd_out_d   = bus.s_wdata;
          end else begin
            rnw_d        = bus.w_rnw;
            w5300_addr_d = bus.w_addr;
            bd_out_d     = bus.w_wdata;
          end
        end
      end
      SETUP: begin
        if (cnt_q == 4'd0) begin
          state_d = STROBE;
          cnt_d   = STROBE_LAST;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LAST;
          if (rnw_q) rdata_d = bus.bd_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          w_ack_d = !gnt_sl_q;
          s_ack_d = gnt_sl_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pin values follow the state being entered, keeping all outputs registered.
    active       = (state_d != IDLE);
    strobe       = (state_d == STROBE);
    busy_d       = active;
    w5300_cs_n_d = !(active && !gnt_sl_d);
    sl811_cs_n_d = !(active && gnt_sl_d);
    brd_n_d      = !(strobe && rnw_d);
    bwr_n_d      = !(strobe && !rnw_d);
    bd_oe_d      = active && !rnw_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      gnt_sl_q     <= 1'b1;
      rnw_q        <= 1'b0;
      w5300_addr_q <= 10'd0;
      sl811_a0_q   <= 1'b0;
      bd_out_q     <= 8'd0;
      rdata_q      <= 8'd0;
      w_ack_q      <= 1'b0;
      s_ack_q      <= 1'b0;
      busy_q       <= 1'b0;
      w5300_cs_n_q <= 1'b1;
      sl811_cs_n_q <= 1'b1;
      brd_n_q      <= 1'b1;
      bwr_n_q      <= 1'b1;
      bd_oe_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gnt_sl_q     <= gnt_sl_d;
      rnw_q        <= rnw_d;
      w5300_addr_q <= w5300_addr_d;
      sl811_a0_q   <= sl811_a0_d;
      bd_out_q     <= bd_out_d;
      rdata_q      <= rdata_d;
      w_ack_q      <= w_ack_d;
      s_ack_q      <= s_ack_d;
      busy_q       <= busy_d;
      w5300_cs_n_q <= w5300_cs_n_d;
      sl811_cs_n_q <= sl811_cs_n_d;
      brd_n_q      <= brd_n_d;
      bwr_n_q      <= bwr_n_d;
      bd_oe_q      <= bd_oe_d;
    end
  end

  assign bus.w_ack      = w_ack_q;
  assign bus.s_ack      = s_ack_q;
  assign bus.rdata      = rdata_q;
  assign bus.busy       = busy_q;
  assign bus.w5300_addr = w5300_addr_q;
  assign bus.w5300_cs_n = w5300_cs_n_q;
  assign bus.sl811_a0   = sl811_a0_q;
  assign bus.sl811_cs_n = sl811_cs_n_q;
  assign bus.brd_n      = brd_n_q;
  assign bus.bwr_n      = bwr_n_q;
  assign bus.bd_out     = bd_out_q;
  assign bus.bd_oe      = bd_oe_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: two instances (default and 2/5/3 timing) share one stimulus
// stream and are compared every cycle against a transfer-timeline model.
module tb_bus_sequencer;

  typedef struct packed {
    logic       rst;
    logic       w_req;
    logic       w_rnw;
    logic [9:0] w_addr;
    logic [7:0] w_wdata;
    logic       s_req;
    logic       s_rnw;
    logic       s_a0;
    logic [7:0] s_wdata;
    logic [7:0] bd_in;
  } ins_t;

  typedef struct packed {
    logic       w_ack;
    logic       s_ack;
    logic [7:0] rdata;
    logic       busy;
    logic [9:0] w5300_addr;
    logic       w5300_cs_n;
    logic       sl811_a0;
    logic       sl811_cs_n;
    logic       brd_n;
    logic       bwr_n;
    logic [7:0] bd_out;
    logic       bd_oe;
  } outs_t;

  typedef struct {
    ins_t       in;
    logic [4:0] flags;   // {w5300_cs_n, bwr_n, bd_oe, w_ack, busy}
  } vec_t;

  logic fclk;
  logic rst;
  logic w_req, w_rnw, s_req, s_rnw, s_a0;
  logic [9:0] w_addr;
  logic [7:0] w_wdata, s_wdata, bd_in;

  bus_sequencer_if if_a ();
  bus_sequencer_if if_b ();

  bus_sequencer u_a (.fclk(fclk), .rst(rst), .bus(if_a.master));
  bus_sequencer #(.T_SETUP(2), .T_STROBE(5), .T_HOLD(3)) u_b (.fclk(fclk), .rst(rst), .bus(if_b.master));

  assign if_a.w_req = w_req;  assign if_b.w_req = w_req;
  assign if_a.w_rnw = w_rnw;  assign if_b.w_rnw = w_rnw;
  assign if_a.w_addr = w_addr;  assign if_b.w_addr = w_addr;
  assign if_a.w_wdata = w_wdata;  assign if_b.w_wdata = w_wdata;
  assign if_a.s_req = s_req;  assign if_b.s_req = s_req;
  assign if_a.s_rnw = s_rnw;  assign if_b.s_rnw = s_rnw;
  assign if_a.s_a0 = s_a0;  assign if_b.s_a0 = s_a0;
  assign if_a.s_wdata = s_wdata;  assign if_b.s_wdata = s_wdata;
  assign if_a.bd_in = bd_in;  assign if_b.bd_in = bd_in;

  outs_t act_a, act_b;
  assign act_a = {if_a.w_ack, if_a.s_ack, if_a.rdata, if_a.busy, if_a.w5300_addr, if_a.w5300_cs_n,
                  if_a.sl811_a0, if_a.sl811_cs_n, if_a.brd_n, if_a.bwr_n, if_a.bd_out, if_a.bd_oe};
  assign act_b = {if_b.w_ack, if_b.s_ack, if_b.rdata, if_b.busy, if_b.w5300_addr, if_b.w5300_cs_n,
                  if_b.sl811_a0, if_b.sl811_cs_n, if_b.brd_n, if_b.bwr_n, if_b.bd_out, if_b.bd_oe};

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: each transfer is a timeline anchored at its grant cycle.
  int ts_p  [2] = '{1, 2};
  int tst_p [2] = '{3, 5};
  int th_p  [2] = '{1, 3};
  int       cyc = 0;
  bit       m_valid = 1'b0;
  bit       m_gv     [2];
  int       m_g      [2];
  bit       m_last_s [2];
  bit       m_rnw    [2];
  logic [9:0] m_addr [2];
  bit       m_a0     [2];
  logic [7:0] m_wd   [2];
  logic [7:0] m_rd   [2];

  outs_t obs_a, obs_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: no response within cycle budget", name);
  endtask

  function automatic outs_t model_out(input int i);
    outs_t o;
    int p, tot;
    bit act, strb;
    tot  = ts_p[i] + tst_p[i] + th_p[i];
    p    = m_gv[i] ? cyc - m_g[i] : -1;
    act  = (p >= 1) && (p <= tot);
    strb = act && (p > ts_p[i]) && (p <= ts_p[i] + tst_p[i]);
    o.busy       = act;
    o.w5300_cs_n = !(act && !m_last_s[i]);
    o.sl811_cs_n = !(act && m_last_s[i]);
    o.brd_n      = !(strb && m_rnw[i]);
    o.bwr_n      = !(strb && !m_rnw[i]);
    o.bd_oe      = act && !m_rnw[i];
    o.bd_out     = o.bd_oe ? m_wd[i] : 8'h00;
    o.w_ack      = (p == tot + 1) && !m_last_s[i];
    o.s_ack      = (p == tot + 1) && m_last_s[i];
    o.rdata      = m_rd[i];
    o.w5300_addr = m_addr[i];
    o.sl811_a0   = m_a0[i];
    return o;
  endfunction

  task automatic model_step(input int i, input ins_t in);
    int p, tot;
    bit pick_s;
    tot = ts_p[i] + tst_p[i] + th_p[i];
    p   = m_gv[i] ? cyc - m_g[i] : -1;
    if (in.rst) begin
      m_gv[i] = 1'b0;  m_rd[i] = 8'h00;  m_addr[i] = 10'h000;
      m_a0[i] = 1'b0;  m_wd[i] = 8'h00;  m_last_s[i] = 1'b1;
      return;
    end
    if (m_gv[i] && m_rnw[i] && p == ts_p[i] + tst_p[i]) m_rd[i] = in.bd_in;
    if ((!m_gv[i] || p >= tot + 2) && (in.w_req || in.s_req)) begin
      pick_s      = in.s_req && (!in.w_req || !m_last_s[i]);
      m_last_s[i] = pick_s;
      m_gv[i]     = 1'b1;
      m_g[i]      = cyc;
      if (pick_s) begin
        m_rnw[i] = in.s_rnw;  m_a0[i] = in.s_a0;  m_wd[i] = in.s_wdata;
      end else begin
        m_rnw[i] = in.w_rnw;  m_addr[i] = in.w_addr;  m_wd[i] = in.w_wdata;
      end
    end
  endtask

  // One cycle: compare this cycle's outputs, then drive the inputs sampled at its closing edge.
  task automatic tick(input ins_t in);
    outs_t e, a;
    @(negedge fclk);
    obs_a = act_a;
    obs_b = act_b;
    if (m_valid) begin
      for (int i = 0; i < 2; i++) begin
        e = model_out(i);
        a = (i == 0) ? obs_a : obs_b;
        if (!e.bd_oe) a.bd_out = 8'h00;
        check((i == 0) ? "model_a" : "model_b", 64'(a), 64'(e));
      end
    end
    rst = in.rst;  w_req = in.w_req;  w_rnw = in.w_rnw;  w_addr = in.w_addr;
    w_wdata = in.w_wdata;  s_req = in.s_req;  s_rnw = in.s_rnw;  s_a0 = in.s_a0;
    s_wdata = in.s_wdata;  bd_in = in.bd_in;
    for (int i = 0; i < 2; i++) model_step(i, in);
    if (in.rst) m_valid = 1'b1;
    cyc++;
  endtask

  ins_t z, rst_in, wi, si;

  task automatic do_reset();
    tick(rst_in);
    tick(rst_in);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl [8];
    outs_t rexp;
    ins_t  in;
    int    cs_low, str_low, bwr_low, wcs_low, ack_at, w_first, s_first, w_ack_k;
    bit    w_done, s_done, seen;
    logic  prev_w, prev_s;
    logic [7:0] rd_at_ack;
    logic [7:0] order;
    int    n_grants, n_acks;

    z = '0;
    rst_in = '0;  rst_in.rst = 1'b1;
    wi = '0;  wi.w_req = 1'b1;  wi.w_rnw = 1'b0;  wi.w_addr = 10'h155;  wi.w_wdata = 8'hA5;
    si = '0;  si.s_req = 1'b1;  si.s_rnw = 1'b1;  si.s_a0 = 1'b1;  si.bd_in = 8'h3C;

    // Reset state
    do_reset();
    tick(z);
    rexp = '0;
    rexp.w5300_cs_n = 1'b1;  rexp.sl811_cs_n = 1'b1;  rexp.brd_n = 1'b1;  rexp.bwr_n = 1'b1;
    check("reset_state", 64'(obs_a), 64'(rexp));

    // Default-timing w5300 write, cycle by cycle from the grant cycle
    tbl[0] = '{wi, 5'b11000};
    tbl[1] = '{wi, 5'b01101};
    tbl[2] = '{wi, 5'b00101};
    tbl[3] = '{wi, 5'b00101};
    tbl[4] = '{wi, 5'b00101};
    tbl[5] = '{wi, 5'b01101};
    tbl[6] = '{wi, 5'b11010};
    tbl[7] = '{z,  5'b11000};
    for (int k = 0; k < 8; k++) begin
      tick(tbl[k].in);
      check($sformatf("write_cyc%0d", k),
            64'({obs_a.w5300_cs_n, obs_a.bwr_n, obs_a.bd_oe, obs_a.w_ack, obs_a.busy}),
            64'(tbl[k].flags));
      if (tbl[k].flags[2]) check($sformatf("write_data%0d", k), 64'(obs_a.bd_out), 64'h00A5);
      if (k == 6) check("write_addr", 64'(obs_a.w5300_addr), 64'h0155);
    end

    // Long timing: cs_n 10 cycles, strobe 5 cycles, ack 11 cycles after grant
    do_reset();
    tick(wi);
    cs_low = 0;  str_low = 0;  ack_at = -1;
    for (int k = 1; k <= 14; k++) begin
      tick((k <= 11) ? wi : z);
      if (!obs_b.w5300_cs_n) cs_low++;
      if (!obs_b.bwr_n) str_low++;
      if (obs_b.w_ack) ack_at = k;
    end
    check("long_cs_cycles", 64'(cs_low), 64'd10);
    check("long_strobe_cycles", 64'(str_low), 64'd5);
    check("long_ack_offset", 64'(ack_at), 64'd11);

    // sl811 read with bd_in = 0x3C
    do_reset();
    cs_low = 0;  str_low = 0;  bwr_low = 0;  wcs_low = 0;  seen = 1'b0;  rd_at_ack = 8'h00;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(si);
      if (!obs_a.sl811_cs_n) cs_low++;
      if (!obs_a.brd_n) str_low++;
      if (!obs_a.bwr_n) bwr_low++;
      if (!obs_a.w5300_cs_n) wcs_low++;
      if (obs_a.s_ack) begin
        seen = 1'b1;
        rd_at_ack = obs_a.rdata;
        check("read_a0", 64'(obs_a.sl811_a0), 64'd1);
      end
    end
    if (!seen) timeout("read_ack");
    check("read_cs_cycles", 64'(cs_low), 64'd5);
    check("read_strobe_cycles", 64'(str_low), 64'd3);
    check("read_no_bwr", 64'(bwr_low), 64'd0);
    check("read_no_w5300_cs", 64'(wcs_low), 64'd0);
    check("read_rdata", 64'(rd_at_ack), 64'h003C);
    tick(z);

    // Simultaneous requests after reset: w5300 first, ack cycle dead, sl811 granted the next cycle
    do_reset();
    w_done = 1'b0;  s_done = 1'b0;  w_first = -1;  s_first = -1;  w_ack_k = -1;
    for (int k = 0; k < 40 && !s_done; k++) begin
      in = z;
      in.w_req = !w_done;  in.w_addr = 10'h2AA;  in.w_wdata = 8'h5A;
      in.s_req = 1'b1;  in.s_rnw = 1'b1;  in.bd_in = 8'hC3;
      tick(in);
      if (!obs_a.w5300_cs_n && w_first < 0) w_first = k;
      if (!obs_a.sl811_cs_n && s_first < 0) s_first = k;
      if (obs_a.w_ack) begin w_done = 1'b1;  w_ack_k = k;  end
      if (obs_a.s_ack) s_done = 1'b1;
    end
    if (!s_done) timeout("tie_s_ack");
    check("tie_w_first", 64'(w_first), 64'd1);
    check("tie_order", 64'(w_first < s_first), 64'd1);
    check("tie_gap", 64'(s_first - w_ack_k), 64'd2);
    tick(z);

    // Both requesters held: grants alternate w, s, w, s
    do_reset();
    in = wi;  in.s_req = 1'b1;  in.s_rnw = 1'b1;
    prev_w = 1'b1;  prev_s = 1'b1;  order = 8'h00;  n_grants = 0;
    for (int k = 0; k < 32; k++) begin
      tick(in);
      if (n_grants < 4 && prev_w && !obs_a.w5300_cs_n) begin
        order = {order[6:0], 1'b0};  n_grants++;
      end
      if (n_grants < 4 && prev_s && !obs_a.sl811_cs_n) begin
        order = {order[6:0], 1'b1};  n_grants++;
      end
      prev_w = obs_a.w5300_cs_n;
      prev_s = obs_a.sl811_cs_n;
    end
    check("rr_grant_count", 64'(n_grants), 64'd4);
    check("rr_order", 64'(order[3:0]), 64'b0101);

    // Reset during the strobe of a read aborts it with no ack and clears rdata
    do_reset();
    in = si;  in.bd_in = 8'h77;  seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(in);
      if (obs_a.s_ack) seen = 1'b1;
    end
    if (!seen) timeout("abort_first_read");
    tick(z);
    check("abort_rdata_before", 64'(obs_a.rdata), 64'h0077);
    in.bd_in = 8'h99;  seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick(in);
      if (!obs_a.brd_n) seen = 1'b1;
    end
    if (!seen) timeout("abort_strobe");
    tick(rst_in);
    tick(z);
    check("abort_pins",
          64'({obs_a.w5300_cs_n, obs_a.sl811_cs_n, obs_a.brd_n, obs_a.bwr_n, obs_a.bd_oe, obs_a.busy}),
          64'b111100);
    check("abort_rdata", 64'(obs_a.rdata), 64'h0000);
    n_acks = 0;
    for (int k = 0; k < 8; k++) begin
      tick(z);
      if (obs_a.s_ack || obs_a.w_ack) n_acks++;
    end
    check("abort_no_ack", 64'(n_acks), 64'd0);

    // Randomized traffic, checked against the model every cycle
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      in.rst     = ($urandom_range(0, 199) == 0);
      in.w_req   = 1'($urandom_range(0, 1));
      in.w_rnw   = 1'($urandom_range(0, 1));
      in.w_addr  = 10'($urandom);
      in.w_wdata = 8'($urandom);
      in.s_req   = 1'($urandom_range(0, 1));
      in.s_rnw   = 1'($urandom_range(0, 1));
      in.s_a0    = 1'($urandom_range(0, 1));
      in.s_wdata = 8'($urandom);
      in.bd_in   = 8'($urandom);
      tick(in);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
